// File: rtl/sysbus_arbiter.sv
// ---------------------------------------------------------------------------
// sysbus_arbiter
//
// Shares the single Sysbus master interface between the instruction-fetch
// requester (port 0) and the data-memory requester (port 1). One port is
// granted at a time. The grant is held for a whole transaction:
//   read  : request beat, then BEATS response beats
//   write : BEATS request beats, where the address beat counts as beat 1
//
// Build option:
//   SYSBUS_ARB_RR_EN  defined   -> round-robin tie-break (the port not served
//                                  last wins; port 0 wins the first tie)
//                     undefined -> fixed priority, port 0 always wins a tie
//
// Ports:
//   clk, reset                       clock, asynchronous active-low reset
//   m0_* / m1_*                      requester ports (0 = fetch, 1 = data)
//     reqcyc/req/reqtag   in         request beat (addr, then write data)
//     reqack              out        request beat accepted
//     respcyc/resp/resptag out       response beat
//     respack             in         response beat consumed
//   bus_reqcyc/req/reqtag out        Sysbus request
//   bus_reqack            in         Sysbus request accept
//   bus_respcyc/resp/resptag in      Sysbus response
//   bus_respack           out        Sysbus response accept
//   owner, busy           out        granted port (valid while busy), lock
// ---------------------------------------------------------------------------
module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      m0_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m0_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m0_reqtag,
    output logic                      m0_reqack,
    output logic                      m0_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m0_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m0_resptag,
    input  logic                      m0_respack,
    input  logic                      m1_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m1_req,
    input  logic [BUS_TAG_WIDTH-1:0]  m1_reqtag,
    output logic                      m1_reqack,
    output logic                      m1_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] m1_resp,
    output logic [BUS_TAG_WIDTH-1:0]  m1_resptag,
    input  logic                      m1_respack,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack,
    output logic                      owner,
    output logic                      busy
);

    // One extra bit so the counter can hold BEATS itself without wrapping.
    localparam int               CNT_W     = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] ONE_BEAT  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_RESP  = 2'd2,
        S_WDATA = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_owner, w_owner_nxt;
    logic [CNT_W-1:0]  r_cnt,   w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_grant;

    // Owner-selected request side.
    logic                      w_own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] w_own_req;
    logic [BUS_TAG_WIDTH-1:0]  w_own_reqtag;
    logic                      w_own_respack;
    logic                      w_req_phase;
    logic                      w_resp_phase;
    logic                      w_req_hs;

    assign w_own_reqcyc  = r_owner ? m1_reqcyc  : m0_reqcyc;
    assign w_own_req     = r_owner ? m1_req     : m0_req;
    assign w_own_reqtag  = r_owner ? m1_reqtag  : m0_reqtag;
    assign w_own_respack = r_owner ? m1_respack : m0_respack;

    assign w_req_phase  = (r_state == S_REQ) || (r_state == S_WDATA);
    assign w_resp_phase = (r_state == S_RESP);
    assign w_req_hs     = w_req_phase && w_own_reqcyc && bus_reqack;
    assign w_cnt_inc    = r_cnt + ONE_BEAT;

`ifdef SYSBUS_ARB_RR_EN
    logic r_last;
    logic w_done;

    // Only a tie consults the pointer; a lone requester always wins.
    assign w_grant = (m0_reqcyc && m1_reqcyc) ? ~r_last : m1_reqcyc;

    // The counter is cleared on every grant, so it can only equal BEATS on
    // the cycle a transaction completes (a cancel leaves it at 0).
    assign w_done = (r_state != S_IDLE) && (w_state_nxt == S_IDLE) &&
                    (w_cnt_nxt == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last <= 1'b1;
        end else if (w_done) begin
            r_last <= r_owner;
        end
    end
`else
    assign w_grant = ~m0_reqcyc;
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (m0_reqcyc || m1_reqcyc) begin
                    w_state_nxt = S_REQ;
                    w_owner_nxt = w_grant;
                    w_cnt_nxt   = '0;
                end
            end
            S_REQ: begin
                if (!w_own_reqcyc) begin
                    w_state_nxt = S_IDLE;          // owner withdrew: cancel
                end else if (bus_reqack) begin
                    if (w_own_reqtag[BUS_TAG_WIDTH-1]) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_RESP;
                    end else begin
                        // The address beat is the first of the write beats.
                        w_cnt_nxt   = ONE_BEAT;
                        w_state_nxt = (ONE_BEAT == LAST_BEAT) ? S_IDLE : S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (w_req_hs) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == LAST_BEAT) w_state_nxt = S_IDLE;
                end
            end
            S_RESP: begin
                if (bus_respack) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == LAST_BEAT) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Combinational passthrough; everything is forced to 0 outside the
    // phase that owns it, and the non-owner always sees 0.
    assign bus_reqcyc  = w_req_phase & w_own_reqcyc;
    assign bus_req     = w_req_phase ? w_own_req    : '0;
    assign bus_reqtag  = w_req_phase ? w_own_reqtag : '0;
    assign bus_respack = w_resp_phase & w_own_respack & bus_respcyc;

    assign m0_reqack  = w_req_phase & ~r_owner & bus_reqack;
    assign m1_reqack  = w_req_phase &  r_owner & bus_reqack;

    assign m0_respcyc = w_resp_phase & ~r_owner & bus_respcyc;
    assign m0_resp    = (w_resp_phase && !r_owner) ? bus_resp    : '0;
    assign m0_resptag = (w_resp_phase && !r_owner) ? bus_resptag : '0;
    assign m1_respcyc = w_resp_phase &  r_owner & bus_respcyc;
    assign m1_resp    = (w_resp_phase &&  r_owner) ? bus_resp    : '0;
    assign m1_resptag = (w_resp_phase &&  r_owner) ? bus_resptag : '0;

    assign busy  = (r_state != S_IDLE);
    assign owner = busy & r_owner;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sysbus_arbiter
//
// Self-checking bench for sysbus_arbiter. Inputs change 1 time unit after the
// rising edge and outputs are sampled on the falling edge. A small reference
// model keeps the "last served" port and decides each grant from the
// arbitration rules; transactions are judged by counting accepted beats.
// ---------------------------------------------------------------------------
module tb_sysbus_arbiter;

    localparam int DW    = 64;
    localparam int TW    = 13;
    localparam int BEATS = 8;
    localparam int NONE  = BEATS + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_reqcyc, m1_reqcyc;
    logic [DW-1:0] m0_req, m1_req;
    logic [TW-1:0] m0_reqtag, m1_reqtag;
    logic          m0_reqack, m1_reqack;
    logic          m0_respcyc, m1_respcyc;
    logic [DW-1:0] m0_resp, m1_resp;
    logic [TW-1:0] m0_resptag, m1_resptag;
    logic          m0_respack, m1_respack;
    logic          bus_reqcyc;
    logic [DW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic [TW-1:0] bus_resptag;
    logic          bus_respack;
    logic          owner, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_last = 1;   // reference pointer: port served last

    always #5 clk = ~clk;

    sysbus_arbiter #(.BUS_DATA_WIDTH(DW), .BUS_TAG_WIDTH(TW), .BEATS(BEATS)) dut (
        .clk(clk), .reset(reset),
        .m0_reqcyc(m0_reqcyc), .m0_req(m0_req), .m0_reqtag(m0_reqtag), .m0_reqack(m0_reqack),
        .m0_respcyc(m0_respcyc), .m0_resp(m0_resp), .m0_resptag(m0_resptag), .m0_respack(m0_respack),
        .m1_reqcyc(m1_reqcyc), .m1_req(m1_req), .m1_reqtag(m1_reqtag), .m1_reqack(m1_reqack),
        .m1_respcyc(m1_respcyc), .m1_resp(m1_resp), .m1_resptag(m1_resptag), .m1_respack(m1_respack),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
        .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respack(bus_respack), .owner(owner), .busy(busy)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_winner(input logic r0, input logic r1);
        if (r0 && r1) begin
`ifdef SYSBUS_ARB_RR_EN
            return 1 - model_last;
`else
            return 0;
`endif
        end
        return r1 ? 1 : 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        return {$urandom, $urandom};
    endfunction

    task automatic set_req(input int p, input logic c, input logic [DW-1:0] a, input logic [TW-1:0] t);
        if (p == 0) begin m0_reqcyc = c; m0_req = a; m0_reqtag = t; end
        else        begin m1_reqcyc = c; m1_req = a; m1_reqtag = t; end
    endtask

    task automatic set_cyc(input int p, input logic c);
        if (p == 0) m0_reqcyc = c; else m1_reqcyc = c;
    endtask

    task automatic set_respack(input int p, input logic v);
        if (p == 0) m0_respack = v; else m1_respack = v;
    endtask

    function automatic logic reqack_of(input int p);
        return (p == 0) ? m0_reqack : m1_reqack;
    endfunction

    function automatic logic respcyc_of(input int p);
        return (p == 0) ? m0_respcyc : m1_respcyc;
    endfunction

    function automatic logic [DW+TW-1:0] resp_of(input int p);
        return (p == 0) ? {m0_resp, m0_resptag} : {m1_resp, m1_resptag};
    endfunction

    task automatic clear_inputs();
        set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);
        m0_respack = 1'b0; m1_respack = 1'b0;
        bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0; bus_resptag = '0;
    endtask

    // Read transaction from the grant edge onward (called at grant edge + 1).
    // abort_at: return right after that many response beats are accepted.
    task automatic finish_read(input int p, input logic [DW-1:0] addr, input logic [TW-1:0] tag,
                               input int ack_dly, input int stall_at, input int stall_len,
                               input int abort_at);
        int beats = 0;
        int stall = 0;
        int cyc   = 0;
        logic give;
        logic ack;
        logic [DW-1:0] d;
        // Request phase; stray response beats here must not be acked.
        for (int i = 0; i <= ack_dly; i++) begin
            bus_reqack  = (i == ack_dly);
            bus_respcyc = 1'($urandom_range(0, 1));
            bus_resp    = rand_data();
            bus_resptag = tag;
            @(negedge clk);
            n_checks++;
            if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, addr, tag}) begin
                n_fail++;
                $display("FAIL rd_req_fwd: got cyc=%b req=%h tag=%h expected cyc=1 req=%h tag=%h",
                         bus_reqcyc, bus_req, bus_reqtag, addr, tag);
            end
            n_checks++;
            if ({busy, owner} !== {1'b1, 1'(p)}) begin
                n_fail++;
                $display("FAIL rd_grant: got busy=%b owner=%b expected busy=1 owner=%0d", busy, owner, p);
            end
            n_checks++;
            if ({reqack_of(p), reqack_of(1 - p)} !== {bus_reqack, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_reqack: got own=%b other=%b expected own=%b other=0",
                         reqack_of(p), reqack_of(1 - p), bus_reqack);
            end
            n_checks++;
            if ({bus_respack, m0_respcyc, m1_respcyc} !== 3'b000) begin
                n_fail++;
                $display("FAIL rd_stray_resp: got respack=%b m0_respcyc=%b m1_respcyc=%b expected 0",
                         bus_respack, m0_respcyc, m1_respcyc);
            end
            step();
        end
        set_cyc(p, 1'b0);
        bus_reqack = 1'b0;
        // Response burst with random gaps and an optional respack stall.
        while (beats < BEATS && cyc < 200) begin
            give = ($urandom_range(0, 3) != 0);
            ack  = 1'b1;
            if (beats == stall_at && stall < stall_len) begin
                give = 1'b1;
                ack  = 1'b0;
                stall++;
            end
            set_respack(p, ack);
            set_respack(1 - p, 1'($urandom_range(0, 1)));
            d = rand_data();
            bus_respcyc = give;
            bus_resp    = d;
            bus_resptag = tag;
            @(negedge clk);
            n_checks++;
            if ({busy, owner, bus_reqcyc} !== {1'b1, 1'(p), 1'b0}) begin
                n_fail++;
                $display("FAIL rd_resp_lock: beat %0d got busy=%b owner=%b bus_reqcyc=%b expected 1/%0d/0",
                         beats, busy, owner, bus_reqcyc, p);
            end
            n_checks++;
            if ({respcyc_of(p), resp_of(p)} !== {give, d, tag}) begin
                n_fail++;
                $display("FAIL rd_resp_fwd: beat %0d got cyc=%b data/tag=%h expected cyc=%b data/tag=%h",
                         beats, respcyc_of(p), resp_of(p), give, {d, tag});
            end
            n_checks++;
            if (bus_respack !== (give && ack)) begin
                n_fail++;
                $display("FAIL rd_respack: beat %0d got %b expected %b", beats, bus_respack, give && ack);
            end
            n_checks++;
            if ({respcyc_of(1 - p), resp_of(1 - p)} !== '0) begin
                n_fail++;
                $display("FAIL rd_nonowner_resp: got cyc=%b data/tag=%h expected all 0",
                         respcyc_of(1 - p), resp_of(1 - p));
            end
            step();
            cyc++;
            if (give && ack) beats++;
            if (beats == abort_at) return;
        end
        n_checks++;
        if (beats != BEATS) begin
            n_fail++;
            $display("FAIL rd_timeout: got %0d beats expected %0d", beats, BEATS);
        end
        bus_respcyc = 1'b0;
        set_respack(p, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({busy, bus_reqcyc, bus_respack} !== 3'b000) begin
            n_fail++;
            $display("FAIL rd_release: got busy=%b bus_reqcyc=%b bus_respack=%b expected 0",
                     busy, bus_reqcyc, bus_respack);
        end
        model_last = p;
    endtask

    // Write transaction from the grant edge onward (called at grant edge + 1).
    task automatic finish_write(input int p, input logic [DW-1:0] addr, input logic [TW-1:0] tag);
        int acked = 0;
        int cyc   = 0;
        logic ack;
        logic [DW-1:0] cur = addr;
        while (acked < BEATS && cyc < 200) begin
            ack = 1'($urandom_range(0, 1));
            bus_reqack = ack;
            @(negedge clk);
            n_checks++;
            if ({busy, owner, bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 1'(p), 1'b1, cur, tag}) begin
                n_fail++;
                $display("FAIL wr_fwd: beat %0d got busy=%b owner=%b cyc=%b req=%h tag=%h expected 1/%0d/1/%h/%h",
                         acked, busy, owner, bus_reqcyc, bus_req, bus_reqtag, p, cur, tag);
            end
            n_checks++;
            if ({reqack_of(p), reqack_of(1 - p), bus_respack} !== {ack, 2'b00}) begin
                n_fail++;
                $display("FAIL wr_reqack: got own=%b other=%b respack=%b expected own=%b other=0 respack=0",
                         reqack_of(p), reqack_of(1 - p), bus_respack, ack);
            end
            step();
            cyc++;
            if (ack) begin
                acked++;
                cur = rand_data();
                set_req(p, 1'b1, cur, tag);
            end
        end
        n_checks++;
        if (acked != BEATS) begin
            n_fail++;
            $display("FAIL wr_timeout: got %0d beats expected %0d", acked, BEATS);
        end
        set_cyc(p, 1'b0);
        bus_reqack = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({busy, bus_reqcyc} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_release: got busy=%b bus_reqcyc=%b expected 0", busy, bus_reqcyc);
        end
        model_last = p;
    endtask

    function automatic logic [TW-1:0] read_tag();
        logic [TW-1:0] t = TW'($urandom);
        t[TW-1] = 1'b1;
        return t;
    endfunction

    function automatic logic [TW-1:0] write_tag();
        logic [TW-1:0] t = TW'($urandom);
        t[TW-1] = 1'b0;
        return t;
    endfunction

    task automatic check_all_zero(input string name);
        n_checks++;
        if ({bus_reqcyc, bus_req, bus_reqtag, bus_respack, busy, owner,
             m0_reqack, m1_reqack, m0_respcyc, m1_respcyc,
             m0_resp, m1_resp, m0_resptag, m1_resptag} !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs not all 0 (bus_reqcyc=%b respack=%b busy=%b owner=%b m0_respcyc=%b m1_respcyc=%b)",
                     name, bus_reqcyc, bus_respack, busy, owner, m0_respcyc, m1_respcyc);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        set_req(0, 1'b1, rand_data(), read_tag());
        set_req(1, 1'b1, rand_data(), write_tag());
        bus_respcyc = 1'b1; bus_reqack = 1'b1; bus_resp = rand_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_outputs");
        clear_inputs();
        reset = 1'b1;
        model_last = 1;
        // Idle with a stray response beat: nothing may be acked.
        bus_respcyc = 1'b1;
        step();
        @(negedge clk);
        check_all_zero("idle_stray_resp");
        bus_respcyc = 1'b0;
    endtask

    task automatic test_single_read();
        set_req(0, 1'b1, 64'h1000, 13'h1100);
        step();
        finish_read(0, 64'h1000, 13'h1100, 1, NONE, 0, NONE);
    endtask

    task automatic test_tie();
        logic [DW-1:0] a [2];
        logic [TW-1:0] t [2];
        int exp;
        for (int p = 0; p < 2; p++) begin
            a[p] = rand_data();
            t[p] = read_tag();
        end
        for (int r = 0; r < 3; r++) begin
            set_req(0, 1'b1, a[0], t[0]);
            set_req(1, 1'b1, a[1], t[1]);
            exp = model_winner(1'b1, 1'b1);
            step();
            finish_read(exp, a[exp], t[exp], int'($urandom_range(0, 2)), NONE, 0, NONE);
            a[exp] = rand_data();
            t[exp] = read_tag();
        end
        set_cyc(0, 1'b0);
        set_cyc(1, 1'b0);
        step();
    endtask

    task automatic test_write();
        logic [DW-1:0] a = rand_data();
        logic [TW-1:0] t = write_tag();
        set_req(1, 1'b1, a, t);
        step();
        finish_write(1, a, t);
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] a = rand_data();
        logic [TW-1:0] t = read_tag();
        set_req(0, 1'b1, a, t);
        step();
        finish_read(0, a, t, 0, 3, 3, NONE);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int p = int'($urandom_range(0, 1));
            logic [DW-1:0] a = rand_data();
            logic [TW-1:0] t;
            if ($urandom_range(0, 1) == 1) begin
                t = read_tag();
                set_req(p, 1'b1, a, t);
                step();
                finish_read(p, a, t, int'($urandom_range(0, 2)), int'($urandom_range(0, BEATS - 1)),
                            int'($urandom_range(0, 3)), NONE);
            end else begin
                t = write_tag();
                set_req(p, 1'b1, a, t);
                step();
                finish_write(p, a, t);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [DW-1:0] a = rand_data();
        logic [TW-1:0] t = read_tag();
        int exp;
        set_req(1, 1'b1, a, t);
        step();
        finish_read(1, a, t, 0, NONE, 0, 4);
        // Still inside the burst: present another beat, then pull reset.
        bus_respcyc = 1'b1;
        m1_respack  = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_burst");
        clear_inputs();
        @(negedge clk);
        reset = 1'b1;
        model_last = 1;
        // Tie straight after reset: pointer is back to "last = port 1".
        set_req(0, 1'b1, a, t);
        set_req(1, 1'b1, rand_data(), read_tag());
        exp = model_winner(1'b1, 1'b1);
        step();
        finish_read(exp, (exp == 0) ? m0_req : m1_req, (exp == 0) ? m0_reqtag : m1_reqtag,
                    0, NONE, 0, NONE);
        set_cyc(0, 1'b0);
        set_cyc(1, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_write();
        test_backpressure();
        test_random();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
